// File: rtl/clock_pkg.sv
// Shared types, limits and load validation for the
// hh:mm:ss BCD time-of-day counter.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t UNITS_MAX    = 4'd9;
    localparam int   HR24_MAX     = 23;
    localparam int   HR12_MIN     = 1;
    localparam int   HR12_MAX     = 12;

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= UNITS_MAX) && (v[3:0] <= UNITS_MAX);
    endfunction

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic valid_time(
        input logic [7:0] hh,
        input logic [7:0] mm,
        input logic [7:0] ss,
        input logic       mode12
    );
        int   h;
        logic ok;
        ok = bcd_ok(hh) && bcd_ok(mm) && bcd_ok(ss)
          && (mm[7:4] <= SEC_TENS_MAX)
          && (ss[7:4] <= SEC_TENS_MAX);
        h = bcd_val(hh);
        if (mode12)
            ok = ok && (h >= HR12_MIN) && (h <= HR12_MAX);
        else
            ok = ok && (h <= HR24_MAX);
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: wraps at MAX, carry when incremented at MAX.
// nxt exposes the value the digit takes on the coming edge.
module bcd_digit_counter
    import clock_pkg::*;
#(
    parameter bcd_t MAX = UNITS_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    input  logic load,
    input  bcd_t ld_val,
    output bcd_t q,
    output bcd_t nxt,
    output logic carry
);

    always_comb begin
        nxt = q;
        if (clear)
            nxt = '0;
        else if (load)
            nxt = ld_val;
        else if (inc)
            nxt = (q == MAX) ? '0 : q + 4'd1;
    end

    assign carry = inc && !clear && !load && (q == MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else
            q <= nxt;
    end

endmodule

// File: rtl/time_of_day_counter.sv
// hh:mm:ss BCD time-of-day counter with prescaler, 12h/24h hours,
// validated load, hh:mm alarm and day-rollover pulse.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int MODE_12H = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       ld_pm,
    input  logic       al_wr,
    input  logic [7:0] al_hh,
    input  logic [7:0] al_mm,
    input  logic       al_pm,
    input  logic       al_en,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       tick_1hz,
    output logic       day_pulse,
    output logic       alarm,
    output logic       ld_err
);

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam bit H12 = (MODE_12H != 0);

    logic [PW-1:0] cnt;
    logic tick_now, load_ok, adv;

    assign tick_now = en && (cnt == PW'(TICK_DIV - 1));
    assign load_ok  = load && valid_time(ld_hh, ld_mm, ld_ss, H12);
    assign adv      = tick_now && !load_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load_ok)
            cnt <= '0;
        else if (en)
            cnt <= tick_now ? '0 : cnt + PW'(1);
    end

    bcd_t ss_u, ss_t, mm_u, mm_t;
    bcd_t ss_u_nxt, ss_t_nxt, mm_u_nxt, mm_t_nxt;
    logic c_ssu, c_sst, c_mmu, c_mmt;

    bcd_digit_counter #(.MAX(UNITS_MAX)) u_ss_u (
        .clk(clk), .reset(reset), .inc(adv), .clear(1'b0),
        .load(load_ok), .ld_val(ld_ss[3:0]),
        .q(ss_u), .nxt(ss_u_nxt), .carry(c_ssu)
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_ss_t (
        .clk(clk), .reset(reset), .inc(c_ssu), .clear(1'b0),
        .load(load_ok), .ld_val(ld_ss[7:4]),
        .q(ss_t), .nxt(ss_t_nxt), .carry(c_sst)
    );
    bcd_digit_counter #(.MAX(UNITS_MAX)) u_mm_u (
        .clk(clk), .reset(reset), .inc(c_sst), .clear(1'b0),
        .load(load_ok), .ld_val(ld_mm[3:0]),
        .q(mm_u), .nxt(mm_u_nxt), .carry(c_mmu)
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_mm_t (
        .clk(clk), .reset(reset), .inc(c_mmu), .clear(1'b0),
        .load(load_ok), .ld_val(ld_mm[7:4]),
        .q(mm_t), .nxt(mm_t_nxt), .carry(c_mmt)
    );

    bcd_t hr_t, hr_u, hr_t_nxt, hr_u_nxt;
    logic pm_q, pm_nxt, day;

    // 12h: 11->12 flips pm (day ends on the pm->am flip), 12->01 keeps pm
    always_comb begin
        hr_t_nxt = hr_t;
        hr_u_nxt = hr_u;
        pm_nxt   = pm_q;
        day      = 1'b0;
        if (load_ok) begin
            hr_t_nxt = ld_hh[7:4];
            hr_u_nxt = ld_hh[3:0];
            pm_nxt   = H12 && ld_pm;
        end else if (c_mmt) begin
            if (!H12 && {hr_t, hr_u} == 8'h23) begin
                hr_t_nxt = 4'd0;
                hr_u_nxt = 4'd0;
                day      = 1'b1;
            end else if (H12 && {hr_t, hr_u} == 8'h12) begin
                hr_t_nxt = 4'd0;
                hr_u_nxt = 4'd1;
            end else if (H12 && {hr_t, hr_u} == 8'h11) begin
                hr_t_nxt = 4'd1;
                hr_u_nxt = 4'd2;
                pm_nxt   = !pm_q;
                day      = pm_q;
            end else if (hr_u == UNITS_MAX) begin
                hr_t_nxt = hr_t + 4'd1;
                hr_u_nxt = 4'd0;
            end else begin
                hr_u_nxt = hr_u + 4'd1;
            end
        end
    end

    logic [7:0] alm_hh, alm_mm;
    logic       alm_pm;
    logic       hit;

    assign hit = adv && al_en
        && ({ss_t_nxt, ss_u_nxt} == 8'h00)
        && ({mm_t_nxt, mm_u_nxt} == alm_mm)
        && ({hr_t_nxt, hr_u_nxt} == alm_hh)
        && (!H12 || (pm_nxt == alm_pm));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hr_t      <= H12 ? 4'd1 : 4'd0;
            hr_u      <= H12 ? 4'd2 : 4'd0;
            pm_q      <= 1'b0;
            alm_hh    <= '0;
            alm_mm    <= '0;
            alm_pm    <= 1'b0;
            tick_1hz  <= 1'b0;
            day_pulse <= 1'b0;
            alarm     <= 1'b0;
            ld_err    <= 1'b0;
        end else begin
            hr_t      <= hr_t_nxt;
            hr_u      <= hr_u_nxt;
            pm_q      <= pm_nxt;
            tick_1hz  <= adv;
            day_pulse <= adv && day;
            alarm     <= hit;
            ld_err    <= load && !load_ok;
            if (al_wr) begin
                alm_hh <= al_hh;
                alm_mm <= al_mm;
                alm_pm <= al_pm;
            end
        end
    end

    assign hh = {hr_t, hr_u};
    assign mm = {mm_t, mm_u};
    assign ss = {ss_t, ss_u};
    assign pm = pm_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Random and directed stimulus on three counter variants, each
// checked every cycle against a seconds-of-day reference model.
module tb_time_of_day_counter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0, load = 1'b0, ld_pm = 1'b0;
    logic al_wr = 1'b0, al_pm = 1'b0, al_en = 1'b0;
    logic [7:0] ld_hh = '0, ld_mm = '0, ld_ss = '0;
    logic [7:0] al_hh = '0, al_mm = '0;

    logic [7:0] hh_o [3];
    logic [7:0] mm_o [3];
    logic [7:0] ss_o [3];
    logic pm_o [3], tk_o [3], dy_o [3], al_o [3], er_o [3];

    always #5 clk = ~clk;

    time_of_day_counter #(.TICK_DIV(4), .MODE_12H(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .al_wr(al_wr), .al_hh(al_hh), .al_mm(al_mm), .al_pm(al_pm),
        .al_en(al_en), .hh(hh_o[0]), .mm(mm_o[0]), .ss(ss_o[0]),
        .pm(pm_o[0]), .tick_1hz(tk_o[0]), .day_pulse(dy_o[0]),
        .alarm(al_o[0]), .ld_err(er_o[0])
    );
    time_of_day_counter #(.TICK_DIV(4), .MODE_12H(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .al_wr(al_wr), .al_hh(al_hh), .al_mm(al_mm), .al_pm(al_pm),
        .al_en(al_en), .hh(hh_o[1]), .mm(mm_o[1]), .ss(ss_o[1]),
        .pm(pm_o[1]), .tick_1hz(tk_o[1]), .day_pulse(dy_o[1]),
        .alarm(al_o[1]), .ld_err(er_o[1])
    );
    time_of_day_counter #(.TICK_DIV(1), .MODE_12H(0)) u2 (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .al_wr(al_wr), .al_hh(al_hh), .al_mm(al_mm), .al_pm(al_pm),
        .al_en(al_en), .hh(hh_o[2]), .mm(mm_o[2]), .ss(ss_o[2]),
        .pm(pm_o[2]), .tick_1hz(tk_o[2]), .day_pulse(dy_o[2]),
        .alarm(al_o[2]), .ld_err(er_o[2])
    );

    typedef struct {
        int t;
        int pc;
        logic [7:0] ahh;
        logic [7:0] amm;
        logic apm;
        logic tick, day, alarm, err;
    } mdl_t;

    mdl_t m [3];
    int   divs [3] = '{4, 4, 1};
    bit   m12 [3]  = '{1'b0, 1'b1, 1'b0};

    int vectors = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [7:0] disp_hh(input int t, input bit h12);
        int h;
        h = t / 3600;
        if (h12) return to_bcd((h % 12 == 0) ? 12 : h % 12);
        return to_bcd(h);
    endfunction

    function automatic logic disp_pm(input int t, input bit h12);
        return h12 && (t / 3600 >= 12);
    endfunction

    // seconds-of-day for the ld_* inputs; ok=0 if not a legal time
    function automatic int ld_secs(input bit h12, output bit ok);
        int ht, hu, mt, mu, st, su, h, mi, s;
        ht = int'(ld_hh[7:4]); hu = int'(ld_hh[3:0]);
        mt = int'(ld_mm[7:4]); mu = int'(ld_mm[3:0]);
        st = int'(ld_ss[7:4]); su = int'(ld_ss[3:0]);
        ok = (ht < 10) && (hu < 10) && (mt < 10) && (mu < 10)
          && (st < 10) && (su < 10);
        h = ht * 10 + hu; mi = mt * 10 + mu; s = st * 10 + su;
        ok = ok && (mi <= 59) && (s <= 59);
        if (h12) begin
            ok = ok && (h >= 1) && (h <= 12);
            h = (h % 12) + (ld_pm ? 12 : 0);
        end else begin
            ok = ok && (h <= 23);
        end
        return h * 3600 + mi * 60 + s;
    endfunction

    function automatic void mreset(input int k);
        m[k].t = 0; m[k].pc = 0;
        m[k].ahh = '0; m[k].amm = '0; m[k].apm = 1'b0;
        m[k].tick = 0; m[k].day = 0; m[k].alarm = 0; m[k].err = 0;
    endfunction

    function automatic void step(input int k);
        mdl_t s, n;
        bit ok, tick;
        int lt;
        s = m[k];
        n = s;
        n.tick = 0; n.day = 0; n.alarm = 0; n.err = 0;
        tick = en && (s.pc == divs[k] - 1);
        lt = ld_secs(m12[k], ok);
        if (load && !ok) n.err = 1;
        if (load && ok) begin
            n.t = lt;
            n.pc = 0;
        end else begin
            if (en) n.pc = tick ? 0 : s.pc + 1;
            if (tick) begin
                n.t = (s.t + 1) % 86400;
                n.tick = 1;
                n.day = (n.t == 0);
                if (al_en && (n.t % 60 == 0)
                    && disp_hh(n.t, m12[k]) == s.ahh
                    && to_bcd((n.t / 60) % 60) == s.amm
                    && (!m12[k] || disp_pm(n.t, 1'b1) == s.apm))
                    n.alarm = 1;
            end
        end
        if (al_wr) begin
            n.ahh = al_hh; n.amm = al_mm; n.apm = al_pm;
        end
        m[k] = n;
    endfunction

    function automatic logic [31:0] expv(input int k);
        return {3'b000, disp_hh(m[k].t, m12[k]),
                to_bcd((m[k].t / 60) % 60), to_bcd(m[k].t % 60),
                disp_pm(m[k].t, m12[k]), m[k].tick, m[k].day,
                m[k].alarm, m[k].err};
    endfunction

    function automatic logic [31:0] gotv(input int k);
        return {3'b000, hh_o[k], mm_o[k], ss_o[k], pm_o[k], tk_o[k],
                dy_o[k], al_o[k], er_o[k]};
    endfunction

    task automatic compare_all(input string tag);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_u%0d", tag, k), gotv(k), expv(k));
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) step(k);
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic ld(input logic [7:0] h, input logic [7:0] mi,
                      input logic [7:0] s, input logic p);
        ld_hh = h; ld_mm = mi; ld_ss = s; ld_pm = p;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic awr(input logic [7:0] h, input logic [7:0] mi,
                       input logic p);
        al_hh = h; al_mm = mi; al_pm = p;
        al_wr = 1'b1;
        cyc();
        al_wr = 1'b0;
    endtask

    int h, mi;

    initial begin
        for (int k = 0; k < 3; k++) mreset(k);
        repeat (2) @(negedge clk);
        compare_all("rst");
        reset = 1'b1;
        en = 1'b1;
        run(9);

        // asynchronous reset in the middle of a count
        #3 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) mreset(k);
        compare_all("arst");
        @(negedge clk);
        compare_all("arst_hold");
        reset = 1'b1;
        run(6);

        ld(8'h23, 8'h59, 8'h58, 1'b0); run(10);
        ld(8'h11, 8'h59, 8'h59, 1'b0); run(5);
        ld(8'h12, 8'h59, 8'h59, 1'b0); run(5);
        ld(8'h11, 8'h59, 8'h59, 1'b1); run(5);

        ld(8'h10, 8'h20, 8'h60, 1'b0); run(2);
        ld(8'h24, 8'h20, 8'h30, 1'b0); run(2);
        ld(8'h1A, 8'h20, 8'h30, 1'b0); run(2);

        al_en = 1'b1;
        awr(8'h00, 8'h01, 1'b0);
        ld(8'h00, 8'h00, 8'h58, 1'b0); run(10);
        al_en = 1'b0;
        ld(8'h00, 8'h00, 8'h58, 1'b0); run(10);
        al_en = 1'b1;
        ld(8'h00, 8'h01, 8'h00, 1'b0); run(3);
        awr(8'h12, 8'h01, 1'b0);
        ld(8'h12, 8'h00, 8'h58, 1'b0); run(10);

        for (int i = 0; i < 40; i++) begin
            en = $urandom_range(0, 1) == 1;
            cyc();
        end

        for (int i = 0; i < 4000; i++) begin
            en = ($urandom % 8) != 0;
            al_en = ($urandom % 8) != 0;
            load = ($urandom % 16) == 0;
            al_wr = 1'b0;
            if (load) begin
                if ($urandom % 8 == 0) begin
                    ld_hh = 8'($urandom); ld_mm = 8'($urandom);
                    ld_ss = 8'($urandom);
                end else begin
                    h = ($urandom % 4 == 0)
                      ? (($urandom % 2 == 1) ? 23 : 11)
                      : int'($urandom % 24);
                    mi = ($urandom % 2 == 1) ? 59 : int'($urandom % 59);
                    ld_hh = to_bcd(h);
                    ld_mm = to_bcd(mi);
                    ld_ss = to_bcd(int'($urandom_range(50, 59)));
                    if ($urandom % 2 == 1) begin
                        al_wr = 1'b1;
                        al_hh = to_bcd((mi == 59) ? (h + 1) % 24 : h);
                        al_mm = to_bcd((mi + 1) % 60);
                        al_pm = $urandom_range(0, 1) == 1;
                    end
                end
                ld_pm = $urandom_range(0, 1) == 1;
            end
            cyc();
        end
        load = 1'b0;
        al_wr = 1'b0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
